// File: rtl/ram_sp_be.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_be
// Description : Single-port RAM with byte-lane write enables, pipelined reads
//               (latency 1 or 2), selectable read-during-write behaviour and
//               an optional zero-fill engine that runs after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_be #(
    parameter int DW             = 16,
    parameter int AW             = 4,
    parameter int OUT_REG        = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,      // asynchronous, active-low
    input  logic [AW-1:0]     adr,
    input  logic [DW-1:0]     dat_w,
    input  logic              we,
    input  logic [DW/8-1:0]   be,
    input  logic              re,
    output logic [DW-1:0]     dat_r,
    output logic              rvalid,
    output logic              busy
);

    localparam int c_nb    = DW / 8;
    localparam int c_depth = 2 ** AW;

    // Byte lanes only make sense for whole bytes; refuse anything else.
    if ((DW % 8) != 0 || DW < 8) begin : g_bad_dw
        $error("ram_sp_be: DW must be a non-zero multiple of 8");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Reset lands in CLEAR only when the zero-fill engine is enabled.
    localparam state_t c_rst_state = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_busy;
    logic            w_acc_we;
    logic            w_acc_re;

    logic [DW-1:0]   r_mem [c_depth];

    logic            w_wr_en;
    logic [AW-1:0]   w_wr_adr;
    logic [DW-1:0]   w_wr_data;
    logic [c_nb-1:0] w_wr_mask;
    logic [DW-1:0]   w_rd_data;

    logic [DW-1:0]   r_dat_r;
    logic            r_rvalid;

    assign w_busy   = (r_state == S_CLEAR);
    assign w_acc_we = we & ~w_busy;
    assign w_acc_re = re & ~w_busy;

    assign busy     = w_busy;
    assign dat_r    = r_dat_r;
    assign rvalid   = r_rvalid;

    // Clear-engine state and address counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_rst_state;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Clear engine walks every address once, leaving after the last one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Write-port source: the clear engine owns the port while busy.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_adr  = adr;
        w_wr_data = dat_w;
        w_wr_mask = be;
        if (w_busy) begin
            w_wr_en   = 1'b1;
            w_wr_adr  = r_cnt;
            w_wr_data = '0;
            w_wr_mask = '1;
        end else if (w_acc_we) begin
            w_wr_en   = 1'b1;
        end
    end

    // Memory array: per-lane masked write, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < c_nb; i++) begin
                if (w_wr_mask[i]) begin
                    r_mem[w_wr_adr][8*i +: 8] <= w_wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read data, optionally forwarding the lanes being written this cycle.
    always_comb begin
        w_rd_data = r_mem[adr];
        if (RDW_MODE != 0 && w_acc_we) begin
            for (int i = 0; i < c_nb; i++) begin
                if (be[i]) begin
                    w_rd_data[8*i +: 8] = dat_w[8*i +: 8];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DW-1:0] r_s1_dat;
        logic          r_s1_vld;

        // Two-stage read pipeline; dat_r only moves when a result arrives.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_s1_dat <= '0;
                r_s1_vld <= 1'b0;
                r_dat_r  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_s1_vld <= w_acc_re;
                if (w_acc_re) begin
                    r_s1_dat <= w_rd_data;
                end
                r_rvalid <= r_s1_vld;
                if (r_s1_vld) begin
                    r_dat_r <= r_s1_dat;
                end
            end
        end
    end else begin : g_no_out_reg
        // Single-stage read; dat_r only moves when a result arrives.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dat_r  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_acc_re;
                if (w_acc_re) begin
                    r_dat_r <= w_rd_data;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sp_be
// Description : Directed self-checking bench for ram_sp_be. Three instances
//               share stimulus: defaults, OUT_REG=1/RDW_MODE=1, and
//               CLEAR_ON_RESET=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sp_be;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic          we;
    logic [1:0]    be;
    logic          re;

    logic [DW-1:0] d0_dat_r, d1_dat_r, d2_dat_r;
    logic          d0_rvalid, d1_rvalid, d2_rvalid;
    logic          d0_busy, d1_busy, d2_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_sp_be #(.DW(DW), .AW(AW), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .adr(adr), .dat_w(dat_w), .we(we), .be(be), .re(re),
        .dat_r(d0_dat_r), .rvalid(d0_rvalid), .busy(d0_busy)
    );

    ram_sp_be #(.DW(DW), .AW(AW), .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .adr(adr), .dat_w(dat_w), .we(we), .be(be), .re(re),
        .dat_r(d1_dat_r), .rvalid(d1_rvalid), .busy(d1_busy)
    );

    ram_sp_be #(.DW(DW), .AW(AW), .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
        .clk(clk), .rst(rst), .adr(adr), .dat_w(dat_w), .we(we), .be(be), .re(re),
        .dat_r(d2_dat_r), .rvalid(d2_rvalid), .busy(d2_busy)
    );

    // One clock of stimulus: drive at negedge, return 1 time unit after posedge.
    task automatic cyc(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] b);
        @(negedge clk);
        we = w; re = r; adr = a; dat_w = d; be = b;
        @(posedge clk);
        #1;
    endtask

    // One-cycle reset pulse with idle inputs; returns at the releasing negedge.
    task automatic pulse_reset();
        @(negedge clk);
        we = 1'b0; re = 1'b0; adr = '0; dat_w = '0; be = '0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1; we = 1'b0; re = 1'b0; adr = '0; dat_w = '0; be = '0;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (d0_dat_r !== 16'h0000) begin n_err++; $display("FAIL rst_dat_r: got %h want 0000", d0_dat_r); end
        n_cmp++; if (d0_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b want 0", d0_rvalid); end
        n_cmp++; if (d0_busy !== 1'b1) begin n_err++; $display("FAIL rst_busy0: got %b want 1", d0_busy); end
        n_cmp++; if (d1_busy !== 1'b1) begin n_err++; $display("FAIL rst_busy1: got %b want 1", d1_busy); end
        n_cmp++; if (d2_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy2: got %b want 0", d2_busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        while (d0_busy && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL clear_len: got %0d want 16", cnt); end
        n_cmp++; if (d1_busy !== 1'b0) begin n_err++; $display("FAIL clear_end1: got %b want 0", d1_busy); end
    endtask

    task automatic test_clear();
        for (int a = 0; a < 16; a++) begin
            cyc(1'b0, 1'b1, AW'(a), 16'h0, 2'b00);
            n_cmp++; if (d0_rvalid !== 1'b1 || d0_dat_r !== 16'h0000) begin
                n_err++; $display("FAIL clear_rd0[%0d]: got v=%b d=%h want v=1 d=0000", a, d0_rvalid, d0_dat_r);
            end
            if (a == 0) begin
                n_cmp++; if (d1_rvalid !== 1'b0) begin n_err++; $display("FAIL clear_lat1: got v=%b want 0", d1_rvalid); end
            end else begin
                n_cmp++; if (d1_rvalid !== 1'b1 || d1_dat_r !== 16'h0000) begin
                    n_err++; $display("FAIL clear_rd1[%0d]: got v=%b d=%h want v=1 d=0000", a - 1, d1_rvalid, d1_dat_r);
                end
            end
        end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
        n_cmp++; if (d1_rvalid !== 1'b1 || d1_dat_r !== 16'h0000) begin
            n_err++; $display("FAIL clear_rd1[15]: got v=%b d=%h want v=1 d=0000", d1_rvalid, d1_dat_r);
        end
        n_cmp++; if (d0_rvalid !== 1'b0) begin n_err++; $display("FAIL clear_tail0: got v=%b want 0", d0_rvalid); end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
    endtask

    task automatic test_byte_enable();
        cyc(1'b1, 1'b0, 4'd3, 16'hA5C3, 2'b11);
        cyc(1'b1, 1'b0, 4'd3, 16'h1234, 2'b01);
        cyc(1'b0, 1'b1, 4'd3, 16'h0000, 2'b00);
        n_cmp++; if (d0_rvalid !== 1'b1 || d0_dat_r !== 16'hA534) begin
            n_err++; $display("FAIL be_merge0: got v=%b d=%h want v=1 d=a534", d0_rvalid, d0_dat_r);
        end
        n_cmp++; if (d2_dat_r !== 16'hA534) begin n_err++; $display("FAIL be_merge2: got %h want a534", d2_dat_r); end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
        n_cmp++; if (d0_rvalid !== 1'b0 || d0_dat_r !== 16'hA534) begin
            n_err++; $display("FAIL be_hold0: got v=%b d=%h want v=0 d=a534", d0_rvalid, d0_dat_r);
        end
        n_cmp++; if (d1_rvalid !== 1'b1 || d1_dat_r !== 16'hA534) begin
            n_err++; $display("FAIL be_merge1: got v=%b d=%h want v=1 d=a534", d1_rvalid, d1_dat_r);
        end
        // Top address, then a write with no lanes enabled must not disturb it.
        cyc(1'b1, 1'b0, 4'd15, 16'hFFFF, 2'b11);
        cyc(1'b1, 1'b0, 4'd15, 16'h0000, 2'b00);
        cyc(1'b0, 1'b1, 4'd15, 16'h0000, 2'b00);
        n_cmp++; if (d0_dat_r !== 16'hFFFF) begin n_err++; $display("FAIL be_zero_top: got %h want ffff", d0_dat_r); end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
    endtask

    task automatic test_rdw();
        cyc(1'b1, 1'b0, 4'd5, 16'h1111, 2'b11);
        cyc(1'b1, 1'b1, 4'd5, 16'h2222, 2'b11);
        n_cmp++; if (d0_dat_r !== 16'h1111) begin n_err++; $display("FAIL rdw_old0: got %h want 1111", d0_dat_r); end
        cyc(1'b0, 1'b1, 4'd5, 16'h0000, 2'b00);
        n_cmp++; if (d1_rvalid !== 1'b1 || d1_dat_r !== 16'h2222) begin
            n_err++; $display("FAIL rdw_new1: got v=%b d=%h want v=1 d=2222", d1_rvalid, d1_dat_r);
        end
        n_cmp++; if (d0_dat_r !== 16'h2222) begin n_err++; $display("FAIL rdw_after0: got %h want 2222", d0_dat_r); end
        // Partial write with read: lane 0 from dat_w, lane 1 from old data.
        cyc(1'b1, 1'b1, 4'd5, 16'h33CC, 2'b01);
        n_cmp++; if (d0_dat_r !== 16'h2222) begin n_err++; $display("FAIL rdw_part0: got %h want 2222", d0_dat_r); end
        n_cmp++; if (d1_dat_r !== 16'h2222) begin n_err++; $display("FAIL rdw_after1: got %h want 2222", d1_dat_r); end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
        n_cmp++; if (d1_dat_r !== 16'h22CC) begin n_err++; $display("FAIL rdw_part1: got %h want 22cc", d1_dat_r); end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp;
        for (int a = 0; a < 4; a++) begin
            cyc(1'b1, 1'b0, AW'(a), 16'h00A0 + 16'(a), 2'b11);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, AW'(k), 16'h0000, 2'b00);
            exp = 16'h00A0 + 16'(k);
            n_cmp++; if (d0_rvalid !== 1'b1 || d0_dat_r !== exp) begin
                n_err++; $display("FAIL b2b_0[%0d]: got v=%b d=%h want v=1 d=%h", k, d0_rvalid, d0_dat_r, exp);
            end
            if (k == 0) begin
                n_cmp++; if (d1_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_lat1: got v=%b want 0", d1_rvalid); end
            end else begin
                exp = 16'h00A0 + 16'(k - 1);
                n_cmp++; if (d1_rvalid !== 1'b1 || d1_dat_r !== exp) begin
                    n_err++; $display("FAIL b2b_1[%0d]: got v=%b d=%h want v=1 d=%h", k - 1, d1_rvalid, d1_dat_r, exp);
                end
            end
        end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
        n_cmp++; if (d1_rvalid !== 1'b1 || d1_dat_r !== 16'h00A3) begin
            n_err++; $display("FAIL b2b_1[3]: got v=%b d=%h want v=1 d=00a3", d1_rvalid, d1_dat_r);
        end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
        n_cmp++; if (d1_rvalid !== 1'b0 || d1_dat_r !== 16'h00A3) begin
            n_err++; $display("FAIL b2b_hold1: got v=%b d=%h want v=0 d=00a3", d1_rvalid, d1_dat_r);
        end
    endtask

    task automatic test_busy_mask();
        int cnt;
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 4'd2, 16'hABCD, 2'b11);
            n_cmp++; if (d0_rvalid !== 1'b0 || d1_rvalid !== 1'b0) begin
                n_err++; $display("FAIL busy_rv[%0d]: got v0=%b v1=%b want 0 0", k, d0_rvalid, d1_rvalid);
            end
        end
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        cnt = 0;
        while (d0_busy && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        n_cmp++; if (d0_busy !== 1'b0) begin n_err++; $display("FAIL busy_timeout: got busy=%b want 0", d0_busy); end
        n_cmp++; if (d1_rvalid !== 1'b0) begin n_err++; $display("FAIL busy_rv_late: got v=%b want 0", d1_rvalid); end
        cyc(1'b0, 1'b1, 4'd2, 16'h0000, 2'b00);
        n_cmp++; if (d0_rvalid !== 1'b1 || d0_dat_r !== 16'h0000) begin
            n_err++; $display("FAIL busy_rd0: got v=%b d=%h want v=1 d=0000", d0_rvalid, d0_dat_r);
        end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
        n_cmp++; if (d1_dat_r !== 16'h0000) begin n_err++; $display("FAIL busy_rd1: got %h want 0000", d1_dat_r); end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        cyc(1'b1, 1'b0, 4'd9, 16'hBEEF, 2'b11);
        // Read launched, then reset while it is still inside dut1's pipeline.
        cyc(1'b0, 1'b1, 4'd9, 16'h0000, 2'b00);
        @(negedge clk);
        re = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++; if (d1_rvalid !== 1'b0) begin n_err++; $display("FAIL flight_rst: got v=%b want 0", d1_rvalid); end
        n_cmp++; if (d0_dat_r !== 16'h0000) begin n_err++; $display("FAIL flight_dat: got %h want 0000", d0_dat_r); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (d1_rvalid !== 1'b0) begin n_err++; $display("FAIL flight_rel: got v=%b want 0", d1_rvalid); end
        // Interrupt the clear at cycle 7 and expect a full restart.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
        end
        pulse_reset();
        cnt = 0;
        while (d0_busy && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        n_cmp++; if (cnt !== 16) begin n_err++; $display("FAIL restart_len: got %0d want 16", cnt); end
        cyc(1'b0, 1'b1, 4'd9, 16'h0000, 2'b00);
        n_cmp++; if (d2_rvalid !== 1'b1 || d2_dat_r !== 16'hBEEF) begin
            n_err++; $display("FAIL keep_beef: got v=%b d=%h want v=1 d=beef", d2_rvalid, d2_dat_r);
        end
        n_cmp++; if (d0_dat_r !== 16'h0000) begin n_err++; $display("FAIL cleared9: got %h want 0000", d0_dat_r); end
        cyc(1'b0, 1'b0, '0, 16'h0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_busy_mask();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_sp_be.md
RAM_SP_BE -- requirements
Module: ram_sp_be

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DW, default 16: data width in bits; must be a multiple of 8, otherwise elaboration fails.
REQ-002 The block SHALL have parameter AW, default 4: address width; depth = 2**AW words.
REQ-003 The block SHALL have parameter OUT_REG, default 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
REQ-004 The block SHALL have parameter RDW_MODE, default 0: read-during-write to the same address returns old data (0) or new merged data (1).
REQ-005 The block SHALL have parameter CLEAR_ON_RESET, default 1: 1 zero-fills the memory after reset; 0 leaves contents untouched.

Ports (name, direction, width, meaning):
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-008 The block SHALL have port adr, input, AW bits: shared read/write word address.
REQ-009 The block SHALL have port dat_w, input, DW bits: write data.
REQ-010 The block SHALL have port we, input, 1 bit: write enable.
REQ-011 The block SHALL have port be, input, DW/8 bits: byte-lane write enables; bit i gates dat_w[8i+7:8i].
REQ-012 The block SHALL have port re, input, 1 bit: read request.
REQ-013 The block SHALL have port dat_r, output, DW bits: read data.
REQ-014 The block SHALL have port rvalid, output, 1 bit: dat_r carries a new read result this cycle.
REQ-015 The block SHALL have port busy, output, 1 bit: clear engine active; requests are ignored while high.

Function
REQ-016 Write: a rising edge with we=1 and busy=0 SHALL update mem[adr] only in the lanes with be[i]=1; we=1 with be all-zero SHALL leave memory unchanged.
REQ-017 Read: re=1 and busy=0 at edge N SHALL present mem[adr] on dat_r, with rvalid=1, at edge N+1 when OUT_REG=0, or at edge N+2 when OUT_REG=1.
REQ-018 Reads SHALL be fully pipelined: back-to-back re every cycle SHALL return one result per cycle, in order.
REQ-019 rvalid SHALL be high for exactly one cycle per accepted read; dat_r SHALL hold its last value when rvalid=0.
REQ-020 Same-cycle we and re at the same adr: RDW_MODE=0 SHALL return pre-write data; RDW_MODE=1 SHALL return written lanes from dat_w and unwritten lanes from old data.
REQ-021 Addresses SHALL be AW bits with no out-of-range case; adr=2**AW-1 SHALL be valid, and no address wrap logic is required.
REQ-022 The clear FSM SHALL have states IDLE and CLEAR; with CLEAR_ON_RESET=1, reset assertion SHALL force CLEAR with the clear counter at 0.
REQ-023 In CLEAR, each cycle SHALL write mem[cnt]=0 and increment cnt; after writing 2**AW-1 the FSM SHALL go to IDLE, so busy lasts exactly 2**AW cycles after reset release.
REQ-024 While busy=1, we and re SHALL be ignored: no write, no rvalid, and no pipeline entry.
REQ-025 With CLEAR_ON_RESET=0, the FSM SHALL remain in IDLE, busy SHALL stay 0, and memory SHALL retain its contents across reset.
REQ-026 Reset asserted mid-clear SHALL restart the clear from address 0 after release.
REQ-027 Reset asserted with reads in flight SHALL discard them, and no rvalid SHALL follow release.

Reset
REQ-028 On rst=0, asynchronously: dat_r=0, rvalid=0, pipeline valid bits=0, and clear counter=0.
REQ-029 During and after reset, busy SHALL be 1 when CLEAR_ON_RESET=1 and 0 when CLEAR_ON_RESET=0; memory array contents SHALL never be reset asynchronously.

Verification
REQ-030 Clear: defaults, release rst -> busy=1 for exactly 16 cycles; afterwards, reading every address -> dat_r=16'h0000 with rvalid=1 one cycle after each re.
REQ-031 Byte enable: write adr=3, dat_w=16'hA5C3, be=2'b11; then write adr=3, dat_w=16'h1234, be=2'b01; read adr=3 -> 16'hA534.
REQ-032 Read-during-write: mem[5]=16'h1111; write 16'h2222 (be=2'b11) with re=1 at adr=5 -> dat_r=16'h1111 for RDW_MODE=0, 16'h2222 for RDW_MODE=1; a following read -> 16'h2222.
REQ-033 Pipelining: OUT_REG=1, re high for 4 cycles on adr=0..3 holding 16'h00A0..16'h00A3 -> rvalid high for 4 consecutive cycles starting 2 edges after the first re, data in order.
REQ-034 Busy masking: we=1 and re=1 at adr=2 during clear -> no rvalid; after clear, read adr=2 -> 16'h0000.
REQ-035 Reset mid-clear: assert rst at clear cycle 7, release -> busy high for a full 16 cycles again; with CLEAR_ON_RESET=0, pre-reset data 16'hBEEF at adr=9 survives reset.
